// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - encodes symbolic instruction fields into 16-bit ISA words and loads them into instruction RAM
// Optional macro WAIT_PAD_EN: append one WAIT word (16'h0000) after the program when capacity remains.
module instr_encode_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_code,
  input  logic [3:0]        in_rdest,
  input  logic [3:0]        in_rsrc,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_run,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MAX_W  = (ADDR_W + 1)'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
`ifdef WAIT_PAD_EN
    S_PAD,
`endif
    S_FINISH,
    S_ERROR
  } state_t;

  state_t            state, state_n;
  logic [15:0]       enc, enc_q;
  logic              enc_illegal;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              err_illegal_q, err_overflow_q;
  logic              full_next;

  assign ram_addr     = addr_q;
  assign word_count   = count_q;
  assign err_illegal  = err_illegal_q;
  assign err_overflow = err_overflow_q;
  assign full_next    = (count_q + 1'b1) == MAX_W;

  always_comb begin
    enc         = 16'h0000;
    enc_illegal = 1'b0;
    case (in_kind)
      2'd0: enc = {4'b0000, in_rdest, in_code, in_rsrc};
      2'd1: begin
        enc         = {in_code, in_rdest, in_imm};
        enc_illegal = (in_code < 4'd5);
      end
      2'd2: begin
        // LOAD and STOR differ only in bit 6 of the word
        if (in_code == 4'd0)      enc = {4'b0100, in_rdest, 4'b0000, in_rsrc};
        else if (in_code == 4'd1) enc = {4'b0100, in_rdest, 4'b0100, in_rsrc};
        else                      enc_illegal = 1'b1;
      end
      default: enc_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_din  = 16'h0000;
    cpu_run  = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_ACCEPT;
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_n = enc_illegal ? S_ERROR : S_WRITE;
      end
      S_WRITE: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        ram_din = enc_q;
        if (last_q || full_next) begin
`ifdef WAIT_PAD_EN
          state_n = full_next ? S_FINISH : S_PAD;
`else
          state_n = S_FINISH;
`endif
        end else begin
          state_n = S_ACCEPT;
        end
      end
`ifdef WAIT_PAD_EN
      S_PAD: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        state_n = S_FINISH;
      end
`endif
      S_FINISH: cpu_run = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      enc_q          <= 16'h0000;
      last_q         <= 1'b0;
      addr_q         <= BASE_A;
      count_q        <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (start) begin
          addr_q         <= BASE_A;
          count_q        <= '0;
          err_illegal_q  <= 1'b0;
          err_overflow_q <= 1'b0;
        end
        S_ACCEPT: if (in_valid) begin
          enc_q  <= enc;
          last_q <= in_last;
          if (enc_illegal) err_illegal_q <= 1'b1;
        end
        S_WRITE: begin
          count_q <= count_q + 1'b1;
          // hold the address on the final slot so it never runs past the window
          if (!full_next) addr_q <= addr_q + 1'b1;
          if (full_next && !last_q) err_overflow_q <= 1'b1;
        end
`ifdef WAIT_PAD_EN
        S_PAD: begin
          count_q <= count_q + 1'b1;
          if (!full_next) addr_q <= addr_q + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - self-checking bench for instr_encode_loader (directed vectors, scoreboard model)
module tb_instr_encode_loader;

  localparam int ADDR_W = 10;
  localparam int BASE   = 0;
  localparam int MAXW   = 4;
`ifdef WAIT_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_kind = '0;
  logic [3:0]        in_code = '0;
  logic [3:0]        in_rdest = '0;
  logic [3:0]        in_rsrc = '0;
  logic [7:0]        in_imm = '0;
  logic              in_last = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic              ram_en, ram_we;
  logic [ADDR_W:0]   word_count;
  logic              cpu_run, err_illegal, err_overflow;

  instr_encode_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_code(in_code), .in_rdest(in_rdest), .in_rsrc(in_rsrc),
    .in_imm(in_imm), .in_last(in_last), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_en(ram_en), .ram_we(ram_we), .word_count(word_count), .cpu_run(cpu_run),
    .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          checking = 1'b0;
  logic [25:0] exp_q[$];
  logic [15:0] obs_mem[0:15];
  int          m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_legal(input int k, input int c);
    if (k == 0) return 1'b1;
    if (k == 1) return c >= 5;
    if (k == 2) return c <= 1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_enc(input int k, input int c, input int rd, input int rs, input int imm);
    if (k == 0) return 16'(rd * 256 + c * 16 + rs);
    if (k == 1) return 16'(c * 4096 + rd * 256 + imm);
    return 16'(16'h4000 + rd * 256 + c * 64 + rs);
  endfunction

  task automatic model_accept(input int k, input int c, input int rd, input int rs, input int imm, input bit lst);
    if (model_legal(k, c)) begin
      exp_q.push_back({ADDR_W'(BASE + m_count), model_enc(k, c, rd, rs, imm)});
      m_count++;
      if ((lst || m_count == MAXW) && PAD && m_count < MAXW) begin
        exp_q.push_back({ADDR_W'(BASE + m_count), 16'h0000});
        m_count++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("en_eq_we", ram_en, ram_we);
      if (ram_we === 1'b1) begin
        check("ready_during_write", in_ready, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %h expected no write", ram_addr, ram_din);
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          check("wr_addr", ram_addr, e[25:16]);
          check("wr_data", ram_din, e[15:0]);
        end
        obs_mem[ram_addr[3:0]] = ram_din;
      end
    end
  end

  task automatic check_reset_state();
    check("rst_ram_addr", ram_addr, BASE);
    check("rst_ram_din", ram_din, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_word_count", word_count, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_err_illegal", err_illegal, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_in_ready", in_ready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    check("exp_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    m_count = 0;
  endtask

  task automatic start_session();
    for (int i = 0; i < 16; i++) obs_mem[i] = 16'hDEAD;
    m_count = 0;
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int k, input int c, input int rd, input int rs, input int imm, input bit lst, output bit acc);
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_kind  = 2'(k);
    in_code  = 4'(c);
    in_rdest = 4'(rd);
    in_rsrc  = 4'(rs);
    in_imm   = 8'(imm);
    in_last  = lst;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
      end else begin
        @(negedge clk); #1;
      end
    end
    if (acc) model_accept(k, c, rd, rs, imm, lst);
  endtask

  task automatic wait_run(input int exp_cycles);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 12 && !seen) begin
      @(negedge clk);
      n++;
      if (cpu_run === 1'b1) seen = 1'b1;
    end
    check("cpu_run_latency", seen ? n : 99, exp_cycles);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int illegal_vec[3][2];
    illegal_vec = '{'{1, 3}, '{2, 2}, '{3, 0}};
    m_count = 0;
    repeat (3) @(negedge clk);
    check_reset_state();
    #1 reset = 1'b0;
    checking = 1'b1;

    check("model_r_add", model_enc(0, 5, 3, 5, 0), 16'h0355);
    check("model_addi", model_enc(1, 5, 2, 0, 8'h7F), 16'h527F);
    check("model_stor", model_enc(2, 1, 1, 4, 0), 16'h4144);
    check("model_load", model_enc(2, 0, 6, 2, 0), 16'h4602);

    start_session();
    send(0, 5, 3, 5, 0, 1'b1, acc);
    check("t1_accept", acc, 1);
    wait_run(PAD ? 3 : 2);
    check("t1_word", obs_mem[0], 16'h0355);
    check("t1_count", word_count, PAD ? 2 : 1);
    if (PAD) check("t1_pad", obs_mem[1], 16'h0000);
    check("t1_err_ill", err_illegal, 0);
    check("t1_err_ovf", err_overflow, 0);
    check("t1_ready_fin", in_ready, 0);
    do_reset();

    start_session();
    send(1, 5, 2, 0, 8'h7F, 1'b0, acc);
    send(2, 1, 1, 4, 0, 1'b1, acc);
    check("t2_accept", acc, 1);
    wait_run(PAD ? 3 : 2);
    check("t2_word0", obs_mem[0], 16'h527F);
    check("t2_word1", obs_mem[1], 16'h4144);
    check("t2_count", word_count, PAD ? 3 : 2);
    do_reset();

    for (int v = 0; v < 3; v++) begin
      start_session();
      send(illegal_vec[v][0], illegal_vec[v][1], 1, 2, 8'h10, 1'b1, acc);
      check("ill_accept", acc, 1);
      #1 in_valid = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("ill_err", err_illegal, 1);
        check("ill_ready", in_ready, 0);
        check("ill_run", cpu_run, 0);
        check("ill_count", word_count, 0);
      end
      send(0, 1, 1, 1, 0, 1'b1, acc);
      check("ill_no_reaccept", acc, 0);
      do_reset();
    end

    start_session();
    for (int i = 0; i < 5; i++) begin
      send(0, i, i, i + 1, 0, 1'b0, acc);
      check("ovf_accept", acc, i < 4);
    end
    #1 in_valid = 1'b0;
    check("ovf_flag", err_overflow, 1);
    check("ovf_run", cpu_run, 1);
    check("ovf_count", word_count, 4);
    check("ovf_word3", obs_mem[3], 16'h0334);
    check("ovf_addr_window", ram_addr <= ADDR_W'(BASE + MAXW - 1), 1);
    do_reset();

    start_session();
    send(1, 9, 4, 0, 8'h22, 1'b0, acc);
    send(0, 7, 1, 2, 0, 1'b0, acc);
    check("mid_accept", acc, 1);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    #1 reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    start_session();
    send(2, 0, 6, 2, 0, 1'b1, acc);
    wait_run(PAD ? 3 : 2);
    check("reload_word", obs_mem[0], 16'h4602);
    check("reload_count", word_count, PAD ? 2 : 1);
    if (PAD) check("reload_pad", obs_mem[1], 16'h0000);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
